// File: rtl/pipe_ctrl_pkg.sv
// Shared types and helpers for the pipeline hazard controller.
// Memory FSM states, forwarding select codes and register-match helpers.
package pipe_ctrl_pkg;

    typedef enum logic {
        IDLE,
        WAIT
    } memState_t;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    // True when a nonzero destination feeds a source the ID instruction reads
    function automatic logic srcHit(
        input logic [4:0] dst,
        input logic [4:0] rs,
        input logic       useRs,
        input logic [4:0] rt,
        input logic       useRt
    );
        return (dst != 5'd0) &&
               ((useRs && (rs == dst)) ||
                (useRt && (rt == dst)));
    endfunction

    function automatic logic [1:0] fwdSel(
        input logic [4:0] src,
        input logic       memFwd,
        input logic [4:0] memDst,
        input logic       wbWr,
        input logic [4:0] wbDst
    );
        if (memFwd && (memDst != 5'd0) && (memDst == src))
            return FWD_MEM;
        if (wbWr && (wbDst != 5'd0) && (wbDst == src))
            return FWD_WB;
        return FWD_REG;
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Data-memory request/acknowledge handshake between the
// hazard controller (master) and the data memory (slave).
interface pipe_hazard_ctrl_if;

    logic dmem_req;
    logic dmem_ack;

    modport master (
        output dmem_req,
        input  dmem_ack
    );

    modport slave (
        input  dmem_req,
        output dmem_ack
    );

endinterface

// File: rtl/mem_wait_fsm.sv
// Multi-cycle data-memory wait FSM with timeout and sticky error.
// Stall is released in the ack cycle or in the last timeout cycle.
import pipe_ctrl_pkg::*;

module mem_wait_fsm #(
    parameter int MEM_TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic memOp,
    input  logic dmemAck,
    output logic dmemReq,
    output logic memStall,
    output logic memErr
);

    localparam int TW = $clog2(MEM_TIMEOUT);
    localparam logic [TW-1:0] TLAST = TW'(MEM_TIMEOUT - 1);

    memState_t     state;
    memState_t     stateNext;
    logic [TW-1:0] timer;
    logic [TW-1:0] timerNext;
    logic          errNext;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            timer  <= '0;
            memErr <= 1'b0;
        end else begin
            state  <= stateNext;
            timer  <= timerNext;
            memErr <= errNext;
        end
    end

    always_comb begin
        stateNext = state;
        timerNext = timer;
        errNext   = memErr;
        unique case (state)
            IDLE: begin
                if (memOp && !dmemAck) begin
                    stateNext = WAIT;
                    timerNext = '0;
                end
            end
            WAIT: begin
                if (dmemAck) begin
                    stateNext = IDLE;
                end else if (timer == TLAST) begin
                    stateNext = IDLE;
                    errNext   = 1'b1;
                end else begin
                    timerNext = timer + TW'(1);
                end
            end
        endcase
    end

    // Outputs are forced low while reset is held, even mid-WAIT
    always_comb begin
        dmemReq  = 1'b0;
        memStall = 1'b0;
        if (rst_n) begin
            unique case (state)
                IDLE: begin
                    dmemReq  = memOp;
                    memStall = memOp && !dmemAck;
                end
                WAIT: begin
                    dmemReq  = 1'b1;
                    memStall = !dmemAck && (timer != TLAST);
                end
            endcase
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard, forwarding and stall control for the 5-stage pipeline.
// Define FORWARDING_EN for EX operand forwarding (load-use stalls only).
import pipe_ctrl_pkg::*;

module pipe_hazard_ctrl #(
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic [4:0]       ex_rs,
    input  logic [4:0]       ex_rt,
    input  logic [4:0]       ex_dst,
    input  logic             ex_regwrite,
    input  logic             ex_memread,
    input  logic [4:0]       mem_dst,
    input  logic             mem_regwrite,
    input  logic             mem_memread,
    input  logic             mem_memwrite,
    input  logic [4:0]       wb_dst,
    input  logic             wb_regwrite,
    input  logic             branch_taken,
    pipe_hazard_ctrl_if.master dmem,
    output logic             pc_hold,
    output logic             ifid_hold,
    output logic             exmem_hold,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             memwb_bubble,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt
);

    logic       memOp;
    logic       memStall;
    logic       dataHaz;
    logic [1:0] fwdA;
    logic [1:0] fwdB;

    assign memOp = mem_memread || mem_memwrite;

    mem_wait_fsm #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) uMemFsm (
        .clk      (clk),
        .rst_n    (rst_n),
        .memOp    (memOp),
        .dmemAck  (dmem.dmem_ack),
        .dmemReq  (dmem.dmem_req),
        .memStall (memStall),
        .memErr   (mem_err)
    );

`ifdef FORWARDING_EN
    logic memFwd;

    assign memFwd  = mem_regwrite && !mem_memread;
    assign dataHaz = ex_memread &&
        srcHit(ex_dst, id_rs, id_use_rs, id_rt, id_use_rt);
    assign fwdA = fwdSel(ex_rs, memFwd, mem_dst, wb_regwrite, wb_dst);
    assign fwdB = fwdSel(ex_rt, memFwd, mem_dst, wb_regwrite, wb_dst);
`else
    logic unusedFwd;

    // No bypass anywhere: every in-flight writer of a used source stalls
    assign dataHaz =
        (ex_regwrite &&
         srcHit(ex_dst, id_rs, id_use_rs, id_rt, id_use_rt)) ||
        (mem_regwrite &&
         srcHit(mem_dst, id_rs, id_use_rs, id_rt, id_use_rt)) ||
        (wb_regwrite &&
         srcHit(wb_dst, id_rs, id_use_rs, id_rt, id_use_rt));
    assign fwdA = FWD_REG;
    assign fwdB = FWD_REG;
    assign unusedFwd = ^{ex_rs, ex_rt, ex_memread};
`endif

    assign fwd_a = rst_n ? fwdA : FWD_REG;
    assign fwd_b = rst_n ? fwdB : FWD_REG;

    always_comb begin
        pc_hold      = 1'b0;
        ifid_hold    = 1'b0;
        exmem_hold   = 1'b0;
        ifid_flush   = 1'b0;
        idex_flush   = 1'b0;
        memwb_bubble = 1'b0;
        if (rst_n) begin
            priority case (1'b1)
                memStall: begin
                    pc_hold      = 1'b1;
                    ifid_hold    = 1'b1;
                    exmem_hold   = 1'b1;
                    memwb_bubble = 1'b1;
                end
                branch_taken: begin
                    ifid_flush = 1'b1;
                    idex_flush = 1'b1;
                end
                dataHaz: begin
                    pc_hold    = 1'b1;
                    ifid_hold  = 1'b1;
                    idex_flush = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_cnt <= '0;
        else if (pc_hold && (stall_cnt != '1))
            stall_cnt <= stall_cnt + CNT_W'(1);
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: the driver queues expected
// outputs per cycle, a negedge monitor pops and compares them.
module tb_pipe_hazard_ctrl;

    localparam logic [11:0] REQ = 12'h800;
    localparam logic [11:0] PCH = 12'h400;
    localparam logic [11:0] IFH = 12'h200;
    localparam logic [11:0] EXH = 12'h100;
    localparam logic [11:0] IFF = 12'h080;
    localparam logic [11:0] IDF = 12'h040;
    localparam logic [11:0] MWB = 12'h020;
    localparam logic [11:0] ERR = 12'h010;
    localparam logic [11:0] ALL = 12'hFFF;
    localparam logic [11:0] STL = REQ | PCH | IFH | EXH | MWB;
    localparam logic [11:0] HZ  = PCH | IFH | IDF;

    typedef struct {
        string       name;
        logic [11:0] ctl;
        logic [11:0] mask;
        bit          chkCnt;
        logic [15:0] cnt;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [4:0]  id_rs, id_rt, ex_rs, ex_rt, ex_dst, mem_dst, wb_dst;
    logic        id_use_rs, id_use_rt, ex_regwrite, ex_memread;
    logic        mem_regwrite, mem_memread, mem_memwrite, wb_regwrite;
    logic        branch_taken;
    logic        pc_hold, ifid_hold, exmem_hold, ifid_flush, idex_flush;
    logic        memwb_bubble, mem_err;
    logic [1:0]  fwd_a, fwd_b;
    logic [15:0] stall_cnt;
    logic [11:0] ctlObs;

    exp_t q[$];
    exp_t e;
    int   compared = 0;
    int   mismatched = 0;

    pipe_hazard_ctrl_if dif ();

    pipe_hazard_ctrl #(
        .CNT_W(16),
        .MEM_TIMEOUT(8)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_use_rs    (id_use_rs),
        .id_use_rt    (id_use_rt),
        .ex_rs        (ex_rs),
        .ex_rt        (ex_rt),
        .ex_dst       (ex_dst),
        .ex_regwrite  (ex_regwrite),
        .ex_memread   (ex_memread),
        .mem_dst      (mem_dst),
        .mem_regwrite (mem_regwrite),
        .mem_memread  (mem_memread),
        .mem_memwrite (mem_memwrite),
        .wb_dst       (wb_dst),
        .wb_regwrite  (wb_regwrite),
        .branch_taken (branch_taken),
        .dmem         (dif),
        .pc_hold      (pc_hold),
        .ifid_hold    (ifid_hold),
        .exmem_hold   (exmem_hold),
        .ifid_flush   (ifid_flush),
        .idex_flush   (idex_flush),
        .memwb_bubble (memwb_bubble),
        .fwd_a        (fwd_a),
        .fwd_b        (fwd_b),
        .mem_err      (mem_err),
        .stall_cnt    (stall_cnt)
    );

    assign ctlObs = {dif.dmem_req, pc_hold, ifid_hold, exmem_hold,
                     ifid_flush, idex_flush, memwb_bubble, mem_err,
                     fwd_a, fwd_b};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, got %0d compared, want completion", compared);
        $fatal(1, "watchdog");
    end

    always @(negedge clk) begin
        if (q.size() > 0) begin
            e = q.pop_front();
            compared++;
            if (((ctlObs ^ e.ctl) & e.mask) != 12'h000) begin
                mismatched++;
                $display("FAIL %s: ctl got %03h want %03h mask %03h",
                         e.name, ctlObs, e.ctl, e.mask);
            end
            if (e.chkCnt) begin
                compared++;
                if (stall_cnt !== e.cnt) begin
                    mismatched++;
                    $display("FAIL %s_cnt: stall_cnt got %0d want %0d",
                             e.name, stall_cnt, e.cnt);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        id_rs = 0; id_rt = 0; id_use_rs = 0; id_use_rt = 0;
        ex_rs = 0; ex_rt = 0; ex_dst = 0;
        ex_regwrite = 0; ex_memread = 0;
        mem_dst = 0; mem_regwrite = 0; mem_memread = 0; mem_memwrite = 0;
        wb_dst = 0; wb_regwrite = 0; branch_taken = 0;
        dif.dmem_ack = 0;
    endtask

    task automatic chk(input string n, input logic [11:0] c,
                       input bit cc, input logic [15:0] cv);
        exp_t r;
        r.name = n; r.ctl = c; r.mask = ALL; r.chkCnt = cc; r.cnt = cv;
        q.push_back(r);
        tick();
    endtask

    initial begin
        clr();
        rst_n = 1'b0;
        branch_taken = 1'b1;
        mem_memread = 1'b1;
        tick();
        chk("reset_forced", 12'h000, 1, 16'd0);
        clr();
        rst_n = 1'b1;
        chk("idle", 12'h000, 1, 16'd0);

        ex_memread = 1; ex_regwrite = 1; ex_dst = 2;
        id_rs = 2; id_use_rs = 1;
        chk("load_use", HZ, 1, 16'd0);
        clr();
        chk("after_load_use", 12'h000, 1, 16'd1);

        ex_memread = 1; ex_regwrite = 1; ex_dst = 2;
        id_rs = 2; id_use_rs = 0; id_rt = 4; id_use_rt = 1;
        chk("src_unused", 12'h000, 0, 16'd0);
        clr();
        ex_memread = 1; ex_regwrite = 1; ex_dst = 0;
        mem_regwrite = 1; id_use_rs = 1;
        chk("dst_zero", 12'h000, 1, 16'd1);

        clr();
        ex_memread = 1; ex_regwrite = 1; ex_dst = 2;
        id_rs = 2; id_use_rs = 1; branch_taken = 1;
        chk("branch_over_load_use", IFF | IDF, 1, 16'd1);

        clr();
        mem_memread = 1;
        chk("mem_idle_miss", STL, 1, 16'd1);
        chk("mem_wait0", STL, 1, 16'd2);
        branch_taken = 1;
        chk("mem_wait1_branch", STL, 1, 16'd3);
        branch_taken = 0;
        chk("mem_wait2", STL, 1, 16'd4);
        dif.dmem_ack = 1; branch_taken = 1;
        chk("mem_ack_branch", REQ | IFF | IDF, 1, 16'd5);
        clr();
        chk("mem_released", 12'h000, 1, 16'd5);

        mem_memwrite = 1; dif.dmem_ack = 1;
        chk("zero_wait", REQ, 1, 16'd5);
        clr();
        chk("zero_wait_cost", 12'h000, 1, 16'd5);

        mem_memread = 1;
        for (int i = 0; i < 8; i++)
            chk("tmo_stall", STL, 0, 16'd0);
        chk("tmo_release", REQ, 1, 16'd13);
        clr();
        chk("tmo_err", ERR, 1, 16'd13);
        mem_memwrite = 1; dif.dmem_ack = 1;
        chk("err_idle_zero_wait", REQ | ERR, 0, 16'd0);
        clr();
        chk("err_sticky", ERR, 1, 16'd13);

        mem_regwrite = 1; mem_dst = 3; wb_regwrite = 1; wb_dst = 3;
        ex_rs = 3; ex_rt = 0;
`ifdef FORWARDING_EN
        chk("fwd_mem", ERR | 12'h008, 0, 16'd0);
`else
        chk("fwd_mem", ERR, 0, 16'd0);
`endif
        mem_regwrite = 0;
`ifdef FORWARDING_EN
        chk("fwd_wb", ERR | 12'h004, 0, 16'd0);
`else
        chk("fwd_wb", ERR, 0, 16'd0);
`endif
        mem_regwrite = 1; mem_dst = 0; ex_rt = 3;
`ifdef FORWARDING_EN
        chk("fwd_both_wb", ERR | 12'h005, 0, 16'd0);
`else
        chk("fwd_both_wb", ERR, 0, 16'd0);
`endif

        clr();
        wb_regwrite = 1; wb_dst = 5; id_rs = 5; id_use_rs = 1;
`ifdef FORWARDING_EN
        chk("wb_raw", ERR, 0, 16'd0);
`else
        chk("wb_raw", ERR | HZ, 0, 16'd0);
`endif
        clr();
        mem_regwrite = 1; mem_dst = 9; id_rt = 9; id_use_rt = 1;
`ifdef FORWARDING_EN
        chk("mem_raw_rt", ERR, 0, 16'd0);
`else
        chk("mem_raw_rt", ERR | HZ, 0, 16'd0);
`endif
        clr();
        ex_regwrite = 1; ex_dst = 12; id_rs = 12; id_use_rs = 1;
`ifdef FORWARDING_EN
        chk("ex_raw_alu", ERR, 0, 16'd0);
`else
        chk("ex_raw_alu", ERR | HZ, 0, 16'd0);
`endif

        clr();
        mem_memread = 1;
        chk("rst_wait_idle", STL | ERR, 0, 16'd0);
        chk("rst_wait_w0", STL | ERR, 0, 16'd0);
        rst_n = 1'b0;
        chk("rst_mid_wait", 12'h000, 1, 16'd0);
        clr();
        rst_n = 1'b1;
        chk("rst_released", 12'h000, 1, 16'd0);
        mem_memwrite = 1; dif.dmem_ack = 1;
        chk("post_rst_zero_wait", REQ, 1, 16'd0);
        clr();

        repeat (2) @(negedge clk);
        if (q.size() != 0) begin
            compared++;
            mismatched++;
            $display("FAIL drain: queue left %0d want 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
